sdram_line_engine: RTL and testbench
====================================

# sdram_line_engine

Cache-line transfer engine that acts as the AXI4-style initiator for the DDR SDRAM controller's user port. It moves fixed-length lines between an internal `LINE_WORDS` x 32-bit line buffer and SDRAM using a single INCR burst per request. Writebacks drain the buffer and reads fill it. Sits between the CPU cache/DMA logic and the SDRAM controller.

## Interface
Parameters:
- `ADDR_BITS`, 26: byte-address width; matches controller `ROW_BITS+COL_BITS+3`.
- `LINE_WORDS`, 8: words per line; power of two, 2..256. `IDX_BITS = log2(LINE_WORDS)`.
- `ID`, 1'b0: value driven on `arw_id`; also the expected `rid`/`bid`.

Ports:
- `clk` in 1: single clock, same as the controller's `clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = buffer-to-SDRAM (writeback), 0 = SDRAM-to-buffer (fill).
- `req_addr` in `ADDR_BITS`: byte address; low `IDX_BITS+2` bits ignored (forced to 0).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky protocol error.
- `buf_we` in 1, `buf_idx` in `IDX_BITS`, `buf_wdata` in 32: user buffer write port.
- `buf_rdata` out 32: combinational `buf[buf_idx]`.
- `arw_valid` out 1, `arw_ready` in 1: address handshake.
- `arw_addr` out `ADDR_BITS`: aligned line address.
- `arw_len` out 8: `LINE_WORDS-1`.
- `arw_write` out 1: direction of the burst.
- `arw_id` out 1: `ID`.
- `arw_size` out 3: 3'd2. `arw_burst` out 2: 2'b01. `wstrb` out 4: 4'hF.
- `wvalid` out 1, `wready` in 1, `wlast` out 1, `wdata` out 32: write data channel.
- `bvalid` in 1, `bready` out 1, `bid` in 1: write response channel.
- `rvalid` in 1, `rready` out 1, `rlast` in 1, `rdata` in 32, `rid` in 1: read data channel.

## Operation
- States: IDLE, ADDR, WDATA, WRESP, RDATA. The beat counter `cnt` is `IDX_BITS` wide.
- **IDLE:** `req_ready`=1. On `req_valid`:
  - latch the aligned address and `req_write`;
  - set `cnt`=0 and clear `err`;
  - go to ADDR.
- **ADDR:** `arw_valid`=1; address and len fields are stable. On `arw_ready`, go to WDATA if write, else RDATA.
- **WDATA:** `wvalid`=1, `wdata`=`buf[cnt]`, `wlast`=(`cnt`==`LINE_WORDS-1`). On `wready`, increment `cnt`; if `wlast`, go to WRESP.
- **WRESP:** `bready`=1. On `bvalid`:
  - set `err` if `bid`!=`ID`;
  - go to IDLE and pulse `done`.
- **RDATA:** `rready`=1 for the whole state. The controller ignores `rready`, so every `rvalid` beat must be accepted. On `rvalid`:
  - write `buf[cnt]`<=`rdata` and increment `cnt`;
  - set `err` if `rid`!=`ID`;
  - end the burst when `rlast` or `cnt`==`LINE_WORDS-1`: go to IDLE and pulse `done`;
  - set `err` if `rlast` and `cnt`!=`LINE_WORDS-1` (short burst), or if `cnt`==`LINE_WORDS-1` and `rlast`=0 (long burst).
- `rvalid` or `bvalid` seen in IDLE/ADDR/WDATA sets `err` and is otherwise ignored.
- Buffer port:
  - `buf_we` is honoured only in IDLE; it is ignored while busy.
  - `buf_we` in the same cycle as an accepted write request is honoured; the first beat is at least 2 cycles later.
  - `buf_rdata` is valid any time; during RDATA it shows partially filled content.
- Reset:
  - asserting `reset_n`=0 in any state forces IDLE immediately and abandons the transaction;
  - the controller shares this reset domain;
  - buffer contents are not reset.

## Timing
- Reset values:
  - `arw_valid`, `wvalid`, `wlast`, `bready`, `rready`, `busy`, `done`, `err` = 0;
  - `req_ready`=1;
  - `arw_addr`=0, `arw_write`=0.
- Constant outputs: `arw_len`, `arw_size`, `arw_burst`, `wstrb`, `arw_id`.
- Request accepted at edge T: `arw_valid` high from T+1.
- With `arw_ready` seen at T+1, the first write beat is presented at T+2.
- One beat per cycle when `wready` is held high.
- `done` is high for exactly one cycle: the first IDLE cycle after the final handshake.
- A new request may be accepted in the same cycle `done` is high (back-to-back).
- All handshakes complete on `valid&&ready` at a rising edge. Outputs are registered or decoded from state, and never depend combinationally on `*_ready`/`*_valid` inputs.

## Test plan
- **Write line:** fill buf with 0x1000+i, issue write to 0x0001234 → `arw_addr`=0x0001220, `arw_len`=7, `arw_write`=1, `wdata` 0x1000..0x1007, `wlast` only on beat 7; `bvalid` → `done` pulse, `err`=0.
- **Read line, back-to-back:** read request at 0x40, controller returns 0xA0..0xA7 → `buf_rdata`[i]=0xA0+i after `done`. A second request on the `done` cycle is accepted with no bubble.
- **Backpressure:** toggle `arw_ready`/`wready` randomly → beat order and values are unchanged, `wvalid`/`wdata` are stable while stalled, and beat count is exactly 8.
- **Errors:**
  - `rlast` on beat 3 → `done` pulse, `err`=1;
  - next request clears `err`;
  - stray `rvalid` in IDLE → `err`=1;
  - `bid`=1 with `ID`=0 → `err`=1.
- **Reset mid-burst:** `reset_n` low during WDATA beat 4 → `wvalid`=0, `busy`=0, `req_ready`=1 asynchronously; the next write completes normally.
- **Buffer access while busy:** `buf_we` during RDATA is ignored; `buf_we` in the same cycle as a write request lands in beat 0.

Source files
------------

// File: rtl/sdram_line_engine.sv
// rtl/sdram_line_engine.sv - cache-line burst initiator for the SDRAM controller user port
//
// Purpose: moves one LINE_WORDS x 32-bit line between an internal line buffer
// and SDRAM with a single INCR burst per request. A writeback drains the
// buffer and a fill loads it.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready, req_write,
//   req_addr                          line request (write = buffer to SDRAM)
//   busy, done, err                   status: not idle, completion pulse, sticky error
//   buf_we, buf_idx, buf_wdata,
//   buf_rdata                         user buffer port (writes honoured only when idle)
//   arw_*                             address channel (shared read/write)
//   wvalid/wready, wlast, wdata, wstrb write data channel
//   bvalid/bready, bid                write response channel
//   rvalid/rready, rlast, rdata, rid  read data channel
module sdram_line_engine #(
  parameter int   ADDR_BITS  = 26,
  parameter int   LINE_WORDS = 8,
  parameter logic ID         = 1'b0,
  localparam int  IDX_BITS   = $clog2(LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 buf_we,
  input  logic [IDX_BITS-1:0]  buf_idx,
  input  logic [31:0]          buf_wdata,
  output logic [31:0]          buf_rdata,
  output logic                 arw_valid,
  input  logic                 arw_ready,
  output logic [ADDR_BITS-1:0] arw_addr,
  output logic [7:0]           arw_len,
  output logic                 arw_write,
  output logic                 arw_id,
  output logic [2:0]           arw_size,
  output logic [1:0]           arw_burst,
  output logic [3:0]           wstrb,
  output logic                 wvalid,
  input  logic                 wready,
  output logic                 wlast,
  output logic [31:0]          wdata,
  input  logic                 bvalid,
  output logic                 bready,
  input  logic                 bid,
  input  logic                 rvalid,
  output logic                 rready,
  input  logic                 rlast,
  input  logic [31:0]          rdata,
  input  logic                 rid
);

  localparam logic [IDX_BITS-1:0]  LAST_IDX   = IDX_BITS'(LINE_WORDS - 1);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ADDR_BITS'((1 << (IDX_BITS + 2)) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRESP,
    S_RDATA
  } state_t;

  state_t                 r_state;
  logic [IDX_BITS-1:0]    r_cnt;
  logic [31:0]            r_buf [LINE_WORDS];

  logic                   r_req_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_arw_valid;
  logic [ADDR_BITS-1:0]   r_arw_addr;
  logic                   r_arw_write;
  logic                   r_wvalid;
  logic                   r_wlast;
  logic                   r_bready;
  logic                   r_rready;

  logic                   w_stray;
  logic                   w_cnt_last;
  logic [IDX_BITS-1:0]    w_cnt_inc;
  logic                   w_buf_user_we;
  logic                   w_buf_fill_we;

  // Response beats arriving before the engine can expect them are protocol errors.
  assign w_stray = (rvalid || bvalid) &&
                   (r_state == S_IDLE || r_state == S_ADDR || r_state == S_WDATA);
  assign w_cnt_last = (r_cnt == LAST_IDX);
  assign w_cnt_inc  = r_cnt + 1'b1;

  // The fill path and the user port never collide: they are gated by disjoint states.
  assign w_buf_user_we = buf_we && (r_state == S_IDLE);
  assign w_buf_fill_we = rvalid && (r_state == S_RDATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_arw_valid <= 1'b0;
      r_arw_addr  <= '0;
      r_arw_write <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_arw_addr  <= req_addr & ~ALIGN_MASK;
            r_arw_write <= req_write;
            r_cnt       <= '0;
            // A new request clears err, but a stray beat in the same cycle still counts.
            r_err       <= w_stray;
            r_state     <= S_ADDR;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_arw_valid <= 1'b1;
          end else if (w_stray) begin
            r_err <= 1'b1;
          end
        end

        S_ADDR: begin
          if (w_stray) begin
            r_err <= 1'b1;
          end
          if (arw_ready) begin
            r_arw_valid <= 1'b0;
            if (r_arw_write) begin
              r_state  <= S_WDATA;
              r_wvalid <= 1'b1;
              r_wlast  <= 1'b0;
            end else begin
              r_state  <= S_RDATA;
              r_rready <= 1'b1;
            end
          end
        end

        S_WDATA: begin
          if (w_stray) begin
            r_err <= 1'b1;
          end
          if (wready) begin
            r_cnt   <= w_cnt_inc;
            r_wlast <= (w_cnt_inc == LAST_IDX);
            if (r_wlast) begin
              r_state  <= S_WRESP;
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
            end
          end
        end

        S_WRESP: begin
          if (bvalid) begin
            if (bid != ID) begin
              r_err <= 1'b1;
            end
            r_state     <= S_IDLE;
            r_bready    <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_done      <= 1'b1;
          end
        end

        S_RDATA: begin
          // rready is advisory only to the controller, so every rvalid is a beat.
          if (rvalid) begin
            r_cnt <= w_cnt_inc;
            if (rid != ID) begin
              r_err <= 1'b1;
            end
            // Short burst (early rlast) or long burst (no rlast on final word).
            if (rlast != w_cnt_last) begin
              r_err <= 1'b1;
            end
            if (rlast || w_cnt_last) begin
              r_state     <= S_IDLE;
              r_rready    <= 1'b0;
              r_busy      <= 1'b0;
              r_req_ready <= 1'b1;
              r_done      <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Line buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_buf_user_we) begin
      r_buf[buf_idx] <= buf_wdata;
    end else if (w_buf_fill_we) begin
      r_buf[r_cnt] <= rdata;
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign arw_valid = r_arw_valid;
  assign arw_addr  = r_arw_addr;
  assign arw_write = r_arw_write;
  assign arw_len   = 8'(LINE_WORDS - 1);
  assign arw_id    = ID;
  assign arw_size  = 3'd2;
  assign arw_burst = 2'b01;
  assign wstrb     = 4'hF;
  assign wvalid    = r_wvalid;
  assign wlast     = r_wlast;
  assign wdata     = r_buf[r_cnt];
  assign bready    = r_bready;
  assign rready    = r_rready;
  assign buf_rdata = r_buf[buf_idx];

endmodule

// File: tb/tb_sdram_line_engine.sv
// tb/tb_sdram_line_engine.sv - directed table-driven bench for sdram_line_engine
module tb_sdram_line_engine;

  localparam int AW = 26;
  localparam int LW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic          busy, done, err;
  logic          buf_we;
  logic [IW-1:0] buf_idx;
  logic [31:0]   buf_wdata, buf_rdata;
  logic          arw_valid, arw_ready;
  logic [AW-1:0] arw_addr;
  logic [7:0]    arw_len;
  logic          arw_write, arw_id;
  logic [2:0]    arw_size;
  logic [1:0]    arw_burst;
  logic [3:0]    wstrb;
  logic          wvalid, wready, wlast;
  logic [31:0]   wdata;
  logic          bvalid, bready, bid;
  logic          rvalid, rready, rlast, rid;
  logic [31:0]   rdata;

  always #5 clk = ~clk;

  sdram_line_engine #(.ADDR_BITS(AW), .LINE_WORDS(LW), .ID(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .busy(busy), .done(done), .err(err),
    .buf_we(buf_we), .buf_idx(buf_idx), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .arw_valid(arw_valid), .arw_ready(arw_ready), .arw_addr(arw_addr), .arw_len(arw_len),
    .arw_write(arw_write), .arw_id(arw_id), .arw_size(arw_size), .arw_burst(arw_burst),
    .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rid(rid)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mdl [LW];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_addr;
    int            rlast_at;   // beat carrying rlast; LW means never
    logic          id_val;
    logic          bp;
    logic          exp_err;
    logic [31:0]   base;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                       input logic bp, input logic same_we, input logic [31:0] same_wd);
    logic ok;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    if (same_we) begin
      buf_we    = 1'b1;
      buf_idx   = '0;
      buf_wdata = same_wd;
      mdl[0]    = same_wd;
    end
    @(negedge clk);
    req_valid = 1'b0;
    buf_we    = 1'b0;
    chk("arw_valid_t1", arw_valid, 1);
    chk("busy_addr", busy, 1);
    chk("err_cleared", err, 0);
    chk("req_ready_busy", req_ready, 0);
    chk("arw_addr", arw_addr, exp_addr);
    chk("arw_write", arw_write, wr);
    chk("arw_len", arw_len, 7);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      arw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arw_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      chk("arw_valid_stall", arw_valid, 1);
      chk("arw_addr_stall", arw_addr, exp_addr);
    end
    chk("arw_handshake", ok, 1);
    @(negedge clk);
    arw_ready = 1'b0;
    chk("arw_valid_drop", arw_valid, 0);
  endtask

  task automatic wdata_phase(input logic bp, input logic bid_val, input logic exp_err);
    int beats = 0;
    int c = 0;
    if (!bp) chk("wvalid_t2", wvalid, 1);
    while (beats < LW && c < 200) begin
      wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, mdl[beats]);
      chk("wlast", wlast, (beats == LW - 1));
      if (wready) beats++;
      @(negedge clk);
      c++;
    end
    wready = 1'b0;
    chk("beat_count", beats, LW);
    chk("wvalid_after", wvalid, 0);
    chk("bready", bready, 1);
    chk("done_early", done, 0);
    bvalid = 1'b1;
    bid    = bid_val;
    @(negedge clk);
    bvalid = 1'b0;
    bid    = 1'b0;
    chk("done_w", done, 1);
    chk("busy_w", busy, 0);
    chk("bready_drop", bready, 0);
    chk("err_w", err, exp_err);
  endtask

  task automatic rdata_phase(input int rlast_at, input logic rid_val, input logic bp,
                             input logic [31:0] base, input logic exp_err);
    int nb;
    nb = (rlast_at < LW - 1) ? rlast_at + 1 : LW;
    chk("rready", rready, 1);
    // A user write into the last slot while busy must be dropped.
    buf_we    = 1'b1;
    buf_idx   = IW'(LW - 1);
    buf_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < nb; i++) begin
      if (bp) begin
        repeat ($urandom_range(0, 2)) begin
          rvalid = 1'b0;
          @(negedge clk);
          buf_we = 1'b0;
          chk("rready_gap", rready, 1);
        end
      end
      rvalid = 1'b1;
      rdata  = base + 32'(i);
      rlast  = (i == rlast_at);
      rid    = rid_val;
      mdl[i] = base + 32'(i);
      chk("done_mid", done, 0);
      @(negedge clk);
      buf_we = 1'b0;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rid    = 1'b0;
    chk("done_r", done, 1);
    chk("busy_r", busy, 0);
    chk("rready_drop", rready, 0);
    chk("err_r", err, exp_err);
  endtask

  task automatic chk_buf();
    for (int i = 0; i < LW; i++) begin
      buf_idx = IW'(i);
      @(negedge clk);
      chk("buf_rdata", buf_rdata, mdl[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    buf_we = 1'b0; buf_idx = '0; buf_wdata = '0;
    arw_ready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = 1'b0;

    vecs[0] = '{1'b1, 26'h0001234, 26'h0001220, LW - 1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 26'h0000040, 26'h0000040, LW - 1, 1'b0, 1'b0, 1'b0, 32'h0000_00A0};
    vecs[2] = '{1'b0, 26'h0000075, 26'h0000060, 3,      1'b0, 1'b0, 1'b1, 32'h0000_0200};
    vecs[3] = '{1'b1, 26'h3FFFFFF, 26'h3FFFFE0, LW - 1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 26'h0000100, 26'h0000100, LW - 1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 26'h0000180, 26'h0000180, LW - 1, 1'b1, 1'b0, 1'b1, 32'h0000_0300};
    vecs[6] = '{1'b0, 26'h00001C0, 26'h00001C0, LW,     1'b0, 1'b0, 1'b1, 32'h0000_0400};
    vecs[7] = '{1'b0, 26'h0000A00, 26'h0000A00, LW - 1, 1'b0, 1'b1, 1'b0, 32'h0000_0500};
    vecs[8] = '{1'b1, 26'h0000A1F, 26'h0000A00, LW - 1, 1'b0, 1'b1, 1'b0, 32'h0};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arw_valid", arw_valid, 0);
    chk("rst_arw_addr", arw_addr, 0);
    chk("rst_arw_write", arw_write, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("const_len", arw_len, 7);
    chk("const_size", arw_size, 2);
    chk("const_burst", arw_burst, 1);
    chk("const_wstrb", wstrb, 4'hF);
    chk("const_id", arw_id, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < LW; i++) begin
      buf_we    = 1'b1;
      buf_idx   = IW'(i);
      buf_wdata = 32'h1000 + 32'(i);
      mdl[i]    = 32'h1000 + 32'(i);
      @(negedge clk);
    end
    buf_we = 1'b0;
    chk_buf();

    for (int k = 0; k < 9; k++) begin
      issue(vecs[k].wr, vecs[k].addr, vecs[k].exp_addr, vecs[k].bp, 1'b0, 32'h0);
      if (vecs[k].wr) wdata_phase(vecs[k].bp, vecs[k].id_val, vecs[k].exp_err);
      else rdata_phase(vecs[k].rlast_at, vecs[k].id_val, vecs[k].bp, vecs[k].base, vecs[k].exp_err);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("err_sticky", err, vecs[k].exp_err);
      chk_buf();
    end

    // Stray rvalid while idle flags an error and leaves the buffer alone.
    rvalid = 1'b1;
    rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    rvalid = 1'b0;
    chk("stray_err", err, 1);
    chk("stray_busy", busy, 0);
    chk_buf();

    // Back-to-back: read, then a write issued in the done cycle.
    issue(1'b0, 26'h0000040, 26'h0000040, 1'b0, 1'b0, 32'h0);
    rdata_phase(LW - 1, 1'b0, 1'b0, 32'h0000_00A0, 1'b0);
    issue(1'b1, 26'h0000080, 26'h0000080, 1'b0, 1'b0, 32'h0);
    wdata_phase(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_buf();

    // buf_we together with an accepted write request lands in beat 0.
    issue(1'b1, 26'h0000300, 26'h0000300, 1'b0, 1'b1, 32'h0BEE_F000);
    wdata_phase(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset during beat 4 of a writeback.
    issue(1'b1, 26'h0000400, 26'h0000400, 1'b0, 1'b0, 32'h0);
    wready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_wvalid", wvalid, 1);
    chk("mid_wdata4", wdata, mdl[4]);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_wvalid", wvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_arw_valid", arw_valid, 0);
    wready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_err", err, 0);
    issue(1'b1, 26'h0000440, 26'h0000440, 1'b0, 1'b0, 32'h0);
    wdata_phase(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("final_done", done, 0);
    chk_buf();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
